// File: rtl/button_cond_if.sv
`default_nettype none
// ============================================================================
// Module   : button_cond_if
// Purpose  : Signal bundle between the front-panel button conditioner and
//            its environment (timing strobes, raw pins, conditioned outputs).
// Revision : 1.0 - initial release
// ============================================================================
interface button_cond_if;
  logic ck35;
  logic n_int;
  logic n_int_next;
  logic magic_btn_n;
  logic pause_btn_n;
  logic magic_button;
  logic pause_button;
  logic reboot_req;
  logic ms_tick;

  modport master (
    output ck35, n_int, n_int_next, magic_btn_n, pause_btn_n,
    input  magic_button, pause_button, reboot_req, ms_tick
  );

  modport slave (
    input  ck35, n_int, n_int_next, magic_btn_n, pause_btn_n,
    output magic_button, pause_button, reboot_req, ms_tick
  );
endinterface
`default_nettype wire

// File: rtl/button_cond.sv
`default_nettype none
// ============================================================================
// Module   : button_cond
// Purpose  : Synchronise, debounce and frame-stretch the MAGIC/PAUSE buttons;
//            flag a long MAGIC hold as a one-cycle reboot request.
// Revision : 1.0 - initial release
// ============================================================================
module button_cond #(
  parameter int MS_DIV      = 3500,
  parameter int DEBOUNCE_MS = 8,
  parameter int LONG_MS     = 2000
) (
  input wire           clk28,
  input wire           rst_n,
  button_cond_if.slave bus
);

  localparam int              c_PW      = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [c_PW-1:0] c_PS_LAST = c_PW'(MS_DIV - 1);
  localparam logic [3:0]      c_DB      = 4'(DEBOUNCE_MS);
  localparam logic [11:0]     c_LONG    = 12'(LONG_MS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESSED  = 2'd1,
    S_REL_WAIT = 2'd2,
    S_LONG     = 2'd3
  } state_t;

  logic [c_PW-1:0] r_ps_cnt;
  logic            r_ms_tick;
  logic            w_frame_edge;
  logic [1:0]      w_raw_n;
  logic [1:0]      w_btn_out;
  logic [1:0]      w_reboot;

  // ms prescaler: exactly MS_DIV ck35 pulses per tick, frozen while ck35 idles
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_ps_cnt  <= '0;
      r_ms_tick <= 1'b0;
    end else begin
      r_ms_tick <= 1'b0;
      if (bus.ck35) begin
        if (r_ps_cnt == c_PS_LAST) begin
          r_ps_cnt  <= '0;
          r_ms_tick <= 1'b1;
        end else begin
          r_ps_cnt <= r_ps_cnt + 1'b1;
        end
      end
    end
  end

  assign w_frame_edge = bus.n_int & ~bus.n_int_next;
  assign w_raw_n      = {bus.pause_btn_n, bus.magic_btn_n};

  // index 0 = MAGIC (with long-press detection), index 1 = PAUSE
  for (genvar g = 0; g < 2; g++) begin : g_btn
    localparam bit c_HAS_LONG = (g == 0);

    logic [1:0]  r_sync;
    logic        w_press_sync;
    logic        r_db;
    logic [3:0]  r_db_cnt;
    state_t      r_state;
    logic        r_seen;
    logic [11:0] r_hold;
    logic        r_out;
    logic        r_reboot;

    always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= 2'b11;
      end else begin
        r_sync <= {r_sync[0], w_raw_n[g]};
      end
    end

    assign w_press_sync = ~r_sync[1];

    // level must differ across DEBOUNCE_MS+1 consecutive ticks to be taken
    always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
        r_db     <= 1'b0;
        r_db_cnt <= '0;
      end else if (w_press_sync == r_db) begin
        r_db_cnt <= '0;
      end else if (r_ms_tick) begin
        if (r_db_cnt == c_DB) begin
          r_db     <= w_press_sync;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 4'd1;
        end
      end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
        r_state  <= S_IDLE;
        r_seen   <= 1'b0;
        r_hold   <= '0;
        r_out    <= 1'b0;
        r_reboot <= 1'b0;
      end else begin
        r_reboot <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (r_db) begin
              r_state <= S_PRESSED;
              r_out   <= 1'b1;
              r_seen  <= 1'b0;
              r_hold  <= '0;
            end
          end
          S_PRESSED: begin
            if (!r_db) begin
              // a frame edge coincident with the release already counts
              if (r_seen || w_frame_edge) begin
                r_state <= S_IDLE;
                r_out   <= 1'b0;
              end else begin
                r_state <= S_REL_WAIT;
              end
            end else begin
              if (w_frame_edge) begin
                r_seen <= 1'b1;
              end
              if (c_HAS_LONG && r_ms_tick) begin
                if (r_hold + 12'd1 == c_LONG) begin
                  r_hold   <= c_LONG;
                  r_reboot <= 1'b1;
                  r_out    <= 1'b0;
                  r_state  <= S_LONG;
                end else if (r_hold != 12'hFFF) begin
                  r_hold <= r_hold + 12'd1;
                end
              end
            end
          end
          S_REL_WAIT: begin
            if (r_db) begin
              r_state <= S_PRESSED;
              r_seen  <= 1'b0;
              r_hold  <= '0;
            end else if (w_frame_edge) begin
              r_state <= S_IDLE;
              r_out   <= 1'b0;
            end
          end
          S_LONG: begin
            if (!r_db) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_out   <= 1'b0;
          end
        endcase
      end
    end

    assign w_btn_out[g] = r_out;
    assign w_reboot[g]  = r_reboot;
  end

  assign bus.magic_button = w_btn_out[0];
  assign bus.pause_button = w_btn_out[1];
  assign bus.reboot_req   = |w_reboot;
  assign bus.ms_tick      = r_ms_tick;

endmodule
`default_nettype wire

// File: tb/tb_button_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_cond
// Purpose  : Directed/randomised bench for button_cond against a per-cycle
//            behavioural model of the conditioning rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_cond;

  localparam int C_MS_DIV = 4;
  localparam int C_DEB    = 2;
  localparam int C_LONG   = 20;
  localparam int C_MS     = C_MS_DIV * 8;

  logic clk28 = 1'b0;
  logic rst_n;
  always #5 clk28 = ~clk28;

  button_cond_if bus ();

  button_cond #(
    .MS_DIV      (C_MS_DIV),
    .DEBOUNCE_MS (C_DEB),
    .LONG_MS     (C_LONG)
  ) dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int reboot_cnt = 0;

  logic magic_raw, pause_raw, ck_en;
  int   fr_period, fr_cnt, ck_phase;
  logic v_ck35, v_nint, v_nint_next;
  logic v_raw[2];

  logic m_s1[2], m_s2[2], m_db[2], m_out[2], m_wait[2], m_seen[2];
  int   m_start[2];
  logic m_long_done, m_tick, m_reboot;
  int   tick_total, ck_total, m_hold;

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic frame_lvl(input int x);
    if (fr_period == 0) return 1'b1;
    return !((x % fr_period) >= fr_period - 4);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 1'b1; m_s2[b] = 1'b1; m_db[b] = 1'b0; m_out[b] = 1'b0;
      m_wait[b] = 1'b0; m_seen[b] = 1'b0; m_start[b] = 0;
    end
    m_long_done = 1'b0; m_tick = 1'b0; m_reboot = 1'b0;
    tick_total = 0; ck_total = 0; m_hold = 0;
  endtask

  // one clk28 edge of the reference behaviour, using the inputs held across it
  task automatic model_step();
    logic fe, tick, psync, db_old;
    fe   = v_nint & ~v_nint_next;
    tick = m_tick;
    m_reboot = 1'b0;
    if (tick) tick_total++;
    for (int b = 0; b < 2; b++) begin
      psync  = ~m_s2[b];
      db_old = m_db[b];
      if (b == 0 && m_long_done) begin
        if (!db_old) m_long_done = 1'b0;
      end else if (!m_out[b]) begin
        if (db_old) begin
          m_out[b] = 1'b1; m_seen[b] = 1'b0; m_wait[b] = 1'b0;
          if (b == 0) m_hold = 0;
        end
      end else if (m_wait[b]) begin
        if (db_old) begin
          m_wait[b] = 1'b0; m_seen[b] = 1'b0;
          if (b == 0) m_hold = 0;
        end else if (fe) begin
          m_out[b] = 1'b0; m_wait[b] = 1'b0;
        end
      end else begin
        if (!db_old) begin
          if (m_seen[b] || fe) m_out[b] = 1'b0;
          else m_wait[b] = 1'b1;
        end else begin
          if (fe) m_seen[b] = 1'b1;
          if (b == 0 && tick) begin
            m_hold++;
            if (m_hold == C_LONG) begin
              m_reboot = 1'b1; m_out[0] = 1'b0; m_long_done = 1'b1;
            end
          end
        end
      end
      // acceptance after DEBOUNCE+1 ticks with the level continuously changed
      if (psync == db_old) begin
        m_start[b] = tick_total;
      end else if (tick && (tick_total - m_start[b] == C_DEB + 1)) begin
        m_db[b] = psync;
        m_start[b] = tick_total;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = v_raw[b];
    end
    m_tick = v_ck35 && ((ck_total % C_MS_DIV) == C_MS_DIV - 1);
    if (v_ck35) ck_total++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk28);
      cyc++;
      check1("magic_button", bus.magic_button, m_out[0]);
      check1("pause_button", bus.pause_button, m_out[1]);
      check1("reboot_req", bus.reboot_req, m_reboot);
      check1("ms_tick", bus.ms_tick, m_tick);
      if (bus.reboot_req === 1'b1) reboot_cnt++;
      v_ck35      = ck_en && ((ck_phase % 8) == 0);
      ck_phase++;
      v_nint      = frame_lvl(fr_cnt);
      v_nint_next = frame_lvl(fr_cnt + 1);
      fr_cnt++;
      v_raw[0] = magic_raw;
      v_raw[1] = pause_raw;
      bus.ck35        = v_ck35;
      bus.n_int       = v_nint;
      bus.n_int_next  = v_nint_next;
      bus.magic_btn_n = v_raw[0];
      bus.pause_btn_n = v_raw[1];
      @(posedge clk28);
      if (rst_n) model_step();
      else model_reset();
    end
  endtask

  task automatic async_reset();
    @(negedge clk28);
    #3 rst_n = 1'b0;
    #1;
    check1("rst_magic", bus.magic_button, 1'b0);
    check1("rst_pause", bus.pause_button, 1'b0);
    check1("rst_reboot", bus.reboot_req, 1'b0);
    check1("rst_ms_tick", bus.ms_tick, 1'b0);
    model_reset();
    run(3);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    magic_raw = 1'b1; pause_raw = 1'b1; ck_en = 1'b1;
    fr_period = 0; fr_cnt = 0; ck_phase = 0;
    v_ck35 = 1'b0; v_nint = 1'b1; v_nint_next = 1'b1;
    v_raw[0] = 1'b1; v_raw[1] = 1'b1;
    bus.ck35 = 1'b0; bus.n_int = 1'b1; bus.n_int_next = 1'b1;
    bus.magic_btn_n = 1'b1; bus.pause_btn_n = 1'b1;
    rst_n = 1'b0;
    model_reset();
    run(3);
    #2 rst_n = 1'b1;
    run(2 * C_MS);

    // clean press and release with frame edges every 5 ms
    fr_period = 5 * C_MS;
    magic_raw = 1'b0; run(10 * C_MS + $urandom_range(0, C_MS - 1));
    check1("clean_held", bus.magic_button, 1'b1);
    magic_raw = 1'b1; run(8 * C_MS);
    check1("clean_released", bus.magic_button, 1'b0);

    // bounce every ~0.5 ms, then settle low
    for (int k = 0; k < 10; k++) begin
      magic_raw = ~magic_raw;
      run(C_MS / 2 + $urandom_range(0, 3));
    end
    check1("bounce_quiet", bus.magic_button, 1'b0);
    magic_raw = 1'b0; run(6 * C_MS);
    check1("bounce_accept", bus.magic_button, 1'b1);
    magic_raw = 1'b1; run(8 * C_MS);

    // frame stretch: no frame edge between accept and release
    fr_period = 0;
    pause_raw = 1'b0; run(4 * C_MS);
    pause_raw = 1'b1; run(6 * C_MS);
    check1("stretch_hold", bus.pause_button, 1'b1);
    fr_period = 2 * C_MS; run(3 * C_MS);
    check1("stretch_drop", bus.pause_button, 1'b0);
    fr_period = 0;
    pause_raw = 1'b0; run(4 * C_MS);
    pause_raw = 1'b1; run(6 * C_MS);
    check1("repress_wait", bus.pause_button, 1'b1);
    pause_raw = 1'b0; run(5 * C_MS);
    check1("repress_held", bus.pause_button, 1'b1);
    fr_period = 5 * C_MS;
    pause_raw = 1'b1; run(12 * C_MS);
    check1("repress_done", bus.pause_button, 1'b0);

    // long MAGIC press: one reboot pulse, nothing more while held
    reboot_cnt = 0;
    magic_raw = 1'b0; run(125 * C_MS);
    checkn("long_single_pulse", reboot_cnt, 1);
    check1("long_out_low", bus.magic_button, 1'b0);
    magic_raw = 1'b1; run(6 * C_MS);
    check1("long_release", bus.magic_button, 1'b0);

    // independence: PAUSE held 50 ms never reboots; both may be high
    reboot_cnt = 0;
    pause_raw = 1'b0; run(10 * C_MS);
    magic_raw = 1'b0; run(10 * C_MS);
    check1("both_magic", bus.magic_button, 1'b1);
    check1("both_pause", bus.pause_button, 1'b1);
    magic_raw = 1'b1; run(30 * C_MS);
    check1("pause_long_held", bus.pause_button, 1'b1);
    pause_raw = 1'b1; run(10 * C_MS);
    checkn("pause_no_reboot", reboot_cnt, 0);

    // ck35 absent: nothing may be accepted
    ck_en = 1'b0;
    magic_raw = 1'b0; run(10 * C_MS);
    check1("stall_no_press", bus.magic_button, 1'b0);
    ck_en = 1'b1; run(6 * C_MS);
    check1("stall_resume", bus.magic_button, 1'b1);
    magic_raw = 1'b1; run(8 * C_MS);

    // asynchronous reset mid-press: full re-debounce and fresh long count
    fr_period = 5 * C_MS;
    magic_raw = 1'b0; run(8 * C_MS);
    check1("pre_reset_pressed", bus.magic_button, 1'b1);
    async_reset();
    reboot_cnt = 0;
    run(C_MS + C_MS / 2);
    check1("post_reset_debounce", bus.magic_button, 1'b0);
    run(20 * C_MS);
    checkn("post_reset_no_early_reboot", reboot_cnt, 0);
    run(3 * C_MS);
    checkn("post_reset_reboot", reboot_cnt, 1);
    magic_raw = 1'b1; run(6 * C_MS);

    // randomised activity against the model
    for (int k = 0; k < 8; k++) begin
      fr_period = $urandom_range(2, 7) * C_MS + $urandom_range(0, 15);
      magic_raw = 1'($urandom_range(0, 1));
      pause_raw = 1'($urandom_range(0, 1));
      run($urandom_range(C_MS / 2, 8 * C_MS));
    end
    magic_raw = 1'b1; pause_raw = 1'b1;
    run(12 * C_MS);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
